writeback_unit: RTL
===================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the datapath width.
REQ-002 SHALL have parameter RD_W, default 4, meaning the register-index width.
REQ-003 SHALL have parameter RA_IDX, default 15, meaning the return-address register written by calls.
REQ-004 SHALL have parameter PC_INC, default 4, meaning the call link offset.
REQ-005 SHALL have parameter LD_TIMEOUT, default 16, meaning the maximum wait cycles for load data.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the instruction handshake.
REQ-009 SHALL have ports alu_result (input, DATA_W) and pc (input, DATA_W): the ALU and PC sources.
REQ-010 SHALL have ports is_ld, is_call and is_wb (inputs, 1 each): load select, call select, and writeback enable.
REQ-011 SHALL have port rd, input, RD_W: the destination register.
REQ-012 SHALL have ports ld_size (input, 2: 00 byte, 01 half, 10 word) and ld_signed (input, 1).
REQ-013 SHALL have ports ld_valid (input, 1) and ld_data (input, DATA_W): the memory response.
REQ-014 SHALL have ports rf_we (output, 1), rf_addr (output, RD_W) and rf_data (output, DATA_W): the register-file write port.
REQ-015 SHALL have ports busy (output, 1) and ld_err (output, 1).

Function
REQ-016 SHALL implement a state machine with states IDLE and WAIT_LD.
REQ-017 SHALL drive in_ready=1 only in IDLE; an instruction is accepted when in_valid & in_ready.
REQ-018 SHALL, for an accepted non-load, select alu_result, or pc+PC_INC when is_call, and register it into rf_data with rf_we=is_wb the next cycle (latency 1).
REQ-019 SHALL, on an accepted call, override rf_addr with RA_IDX and force rf_we=1 regardless of is_wb and rd.
REQ-020 SHALL give is_call priority when is_ld and is_call are both 1; the instruction is handled as a call.
REQ-021 SHALL compute pc+PC_INC modulo 2^DATA_W (wrap, no carry out).
REQ-022 SHALL, on an accepted load (is_ld=1, is_call=0), latch rd, ld_size, ld_signed and is_wb, then enter WAIT_LD.
REQ-023 SHALL ignore ld_valid in IDLE.
REQ-024 SHALL, in WAIT_LD on ld_valid=1, extend ld_data[7:0], ld_data[15:0] or the full word per ld_size (sign- or zero-extension per ld_signed), register the result to rf_data with rf_we=latched is_wb the next cycle, and return to IDLE.
REQ-025 SHALL treat ld_size=11 as word.
REQ-026 SHALL count WAIT_LD cycles; if LD_TIMEOUT cycles pass without ld_valid, it pulses ld_err for 1 cycle, performs no write, and returns to IDLE.
REQ-027 SHALL, if ld_valid arrives in the same cycle the count reaches LD_TIMEOUT, accept the data with no error.
REQ-028 SHALL hold rf_we for exactly one cycle per write.
REQ-029 SHALL hold rf_data and rf_addr at their last values when rf_we=0.
REQ-030 SHALL drive busy=1 exactly in WAIT_LD.
REQ-031 SHALL allow back-to-back non-loads at one per cycle.

Reset
REQ-032 SHALL, while rst=1, set state to IDLE, counter to 0, and rf_we, ld_err and busy to 0.
REQ-033 SHALL, while rst=1, set rf_data and rf_addr to 0.
REQ-034 SHALL, on rst during WAIT_LD, abandon the pending load without any write or error pulse.

Structure
REQ-035 SHALL place the ld_size encodings and the state enumeration in the shared processor package.
REQ-036 SHALL implement load extension in one combinational sub-module named load_extend.

Verification
REQ-037 SHALL cover this scenario: ALU op with alu_result=0x0000_00A5, rd=3, is_wb=1 -> the next cycle gives rf_we=1, rf_addr=3, rf_data=0x0000_00A5.
REQ-038 SHALL cover this scenario: call with pc=0xFFFF_FFFE, rd=7, is_wb=0 -> rf_addr=15, rf_data=0x0000_0002, rf_we=1.
REQ-039 SHALL cover this scenario: byte load, signed, ld_data=0x1234_5680 after 3 wait cycles -> busy for 3 cycles, then rf_data=0xFFFF_FF80; the same unsigned gives 0x0000_0080.
REQ-040 SHALL cover this scenario: load with no ld_valid for 16 cycles -> one ld_err pulse, no rf_we, in_ready=1 afterwards.
REQ-041 SHALL cover this scenario: rst asserted 2 cycles into WAIT_LD, then ld_valid -> no write, state IDLE, all outputs 0.
REQ-042 SHALL cover this scenario: is_ld=1 and is_call=1 together -> treated as a call, no WAIT_LD entry.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared processor definitions for the writeback path: load-size encodings
// and the writeback controller state enumeration.
package writeback_unit_pkg;

  typedef enum logic [1:0] {
    LD_BYTE   = 2'b00,
    LD_HALF   = 2'b01,
    LD_WORD   = 2'b10,
    LD_WORD_X = 2'b11   // unused encoding, behaves as a word load
  } ld_size_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAIT_LD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_unit_load_extend.sv
// Combinational load-data extension: picks byte, half or word from the
// memory response and sign- or zero-extends it to the datapath width.
module load_extend
  import writeback_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        size,
  input  logic              sgn,
  output logic [DATA_W-1:0] ext
);

  logic byte_fill;
  logic half_fill;

  assign byte_fill = sgn & data[7];
  assign half_fill = sgn & data[15];

  // Select the access width and replicate the fill bit above it.
  always_comb begin
    ext = data;
    case (ld_size_e'(size))
      LD_BYTE: ext = {{(DATA_W-8){byte_fill}}, data[7:0]};
      LD_HALF: ext = {{(DATA_W-16){half_fill}}, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: registers ALU results and call link addresses into the
// register file with one cycle of latency, and waits (with a timeout) for
// load data, which it extends before writing back.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RD_W       = 4,
  parameter int RA_IDX     = 15,
  parameter int PC_INC     = 4,
  parameter int LD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] pc,
  input  logic              is_ld,
  input  logic              is_call,
  input  logic              is_wb,
  input  logic [RD_W-1:0]   rd,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              rf_we,
  output logic [RD_W-1:0]   rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              busy,
  output logic              ld_err
);

  localparam int CNT_W = $clog2(LD_TIMEOUT + 1);

  wb_state_e         state;
  wb_state_e         state_next;
  logic [CNT_W-1:0]  cnt;

  logic              take_call;
  logic              take_alu;
  logic              take_ld;
  logic              ld_done;
  logic              ld_tmo;

  // Load context captured at acceptance, used when the response returns.
  logic [RD_W-1:0]   ld_rd_p1;
  logic [1:0]        ld_size_p1;
  logic              ld_signed_p1;
  logic              ld_wb_p1;

  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] link_addr;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_WAIT_LD);
  // Wraps naturally at DATA_W bits; the carry out is discarded.
  assign link_addr = pc + DATA_W'(PC_INC);

  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .data (ld_data),
    .size (ld_size_p1),
    .sgn  (ld_signed_p1),
    .ext  (ext_data)
  );

  // State register and wait counter; the counter runs only while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_WAIT_LD && state_next == ST_WAIT_LD) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  // Next-state and per-cycle decisions. A call wins over a load, so only
  // a pure load enters the wait state. Data arriving on the same cycle the
  // count reaches the timeout is still accepted.
  always_comb begin
    state_next = state;
    take_call  = 1'b0;
    take_alu   = 1'b0;
    take_ld    = 1'b0;
    ld_done    = 1'b0;
    ld_tmo     = 1'b0;
    case (state)
      ST_IDLE: begin
        take_call = in_valid & is_call;
        take_ld   = in_valid & is_ld & ~is_call;
        take_alu  = in_valid & ~is_ld & ~is_call;
        if (take_ld) begin
          state_next = ST_WAIT_LD;
        end
      end
      ST_WAIT_LD: begin
        if (ld_valid) begin
          ld_done    = 1'b1;
          state_next = ST_IDLE;
        end else if (cnt == CNT_W'(LD_TIMEOUT)) begin
          ld_tmo     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture load context on acceptance.
  always_ff @(posedge clk) begin
    if (take_ld) begin
      ld_rd_p1     <= rd;
      ld_size_p1   <= ld_size;
      ld_signed_p1 <= ld_signed;
      ld_wb_p1     <= is_wb;
    end
  end

  // Register-file write port; address and data only move on a real write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we   <= 1'b0;
      ld_err  <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      rf_we  <= 1'b0;
      ld_err <= ld_tmo;
      if (take_call) begin
        rf_we   <= 1'b1;
        rf_addr <= RD_W'(RA_IDX);
        rf_data <= link_addr;
      end else if (take_alu && is_wb) begin
        rf_we   <= 1'b1;
        rf_addr <= rd;
        rf_data <= alu_result;
      end else if (ld_done && ld_wb_p1) begin
        rf_we   <= 1'b1;
        rf_addr <= ld_rd_p1;
        rf_data <= ext_data;
      end
    end
  end

endmodule
